uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO and a valid/ready input handshake. It serialises DW-bit words as start, data (LSB first), optional parity and one or two stop bits, at BAUD_COUNTER clocks per bit. It replaces the single-byte transmitter on the serial output path, so producers can queue bursts without per-byte pacing. Queued words go out back-to-back with no idle gap between frames.

## Interface
- DW, 8: data bits per frame, 5..9.
- CLOCK, 100e6: clock frequency in Hz.
- BAUD_RATE, 20000000: bit rate in bit/s.
- BAUD_COUNTER, CLOCK/BAUD_RATE: clocks per bit, integer, >= 1.
- BRW, $clog2(BAUD_COUNTER+1): baud counter width.
- FIFO_DEPTH, 4: FIFO entries, power of two, >= 2.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  DW  word to transmit.
- valid_i  in  1  data_i valid.
- ready_o  out  1  FIFO can accept; transfer when valid_i && ready_o at an edge.
- Tx  out  1  serial line, idle high, registered.
- busy_o  out  1  frame in progress (START through last STOP).
- fifo_count_o  out  $clog2(FIFO_DEPTH+1)  words queued, excluding the one in flight.

## Operation
- Reset (rst_i high at an edge): Tx=1, busy_o=0, fifo_count_o=0, FIFO pointers 0, FSM IDLE, baud counter 0. ready_o is held 0 while rst_i is high; transfers presented during reset are dropped.
- ready_o = !full, combinational from count. When full, no push occurs even if a pop happens in the same cycle.
- FIFO: circular buffer with pointers that wrap at FIFO_DEPTH. Simultaneous push and pop leaves count unchanged.
- FSM states and transitions:
  - IDLE → START: when count != 0. The FIFO is popped into the shift register and Tx <= 0.
  - START → DATA.
  - DATA → PARITY (if PARITY != 0) or STOP. DATA sends DW bits, LSB first.
  - PARITY → STOP.
  - STOP → START: after STOP_BITS high bits, if count != 0. Pop happens at the terminal edge.
  - STOP → IDLE: after STOP_BITS high bits, if count == 0.
- Each state/bit holds for exactly BAUD_COUNTER clocks. The baud counter counts 0..BAUD_COUNTER-1. The bit advances on the terminal count, and the counter reloads 0.
- Parity bit:
  - Even: ^word, so total ones including parity is even.
  - Odd: ~^word.
- Frame length is exactly BAUD_COUNTER*(1+DW+(PARITY!=0)+STOP_BITS) clocks.
- busy_o is high in START/DATA/PARITY/STOP.
- Reset mid-frame: the frame aborts at the same edge, Tx=1 next cycle, and the FIFO is flushed.
- Input data_i is sampled only at the accepting edge. Later changes do not affect queued words.

## Timing
- Latency: word accepted at edge E0 into an empty FIFO with FSM IDLE → popped at E1, Tx low from E1 for BAUD_COUNTER cycles. fifo_count_o reads 1 between E0 and E1.
- Back-to-back frames: the next start bit begins on the cycle after the last stop bit's final clock; zero idle cycles.
- After the last frame, Tx stays 1 and busy_o falls at the same edge FSM enters IDLE.
- fifo_count_o and ready_o update on the edge after push/pop.

## Test plan
- Test parameters: CLOCK=100e6, BAUD_RATE=20e6 (BAUD_COUNTER=5), DW=8, FIFO_DEPTH=4 unless stated.
- PARITY=0, STOP_BITS=1; push 0xA5 once.
  - Tx: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each bit 5 cycles.
  - busy_o high exactly 50 cycles; Tx low 1 cycle after accept.
- Parity: push 0xF0.
  - PARITY=2: parity bit 0, frame 55 cycles.
  - PARITY=1: parity bit 1.
  - Push 0x07 with PARITY=2: parity bit 1.
- Burst: hold valid_i, push 0x01..0x06 on consecutive cycles.
  - 0x01 popped at once; 0x02..0x05 fill FIFO, count 4, ready_o low.
  - 0x06 accepted the cycle after 0x02 is popped, i.e. 50 cycles after the 0x01 start.
  - Six contiguous frames, no idle gaps, 300 cycles of busy_o.
- STOP_BITS=2, PARITY=0: push 0x00, 0xFF back-to-back.
  - Stop interval 10 cycles high; second start immediately follows; each frame 55 cycles.
- Reset mid-frame: with 2 words queued, assert rst_i for 1 cycle during data bit 3.
  - Next cycle: Tx=1, busy_o=0, fifo_count_o=0, ready_o=1 after release.
  - No further frames; a valid_i presented during the reset cycle is dropped.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake bundle for uart_tx_fifo.
//   data  : word to transmit (DW bits)
//   valid : data holds a word to queue
//   ready : transmitter can accept a word this cycle
// A word transfers on a rising clock edge where valid && ready.
// The transmitter connects through the slave modport, the producer through master.
interface uart_tx_fifo_if #(
  parameter int DW = 8
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO in front of it. Words arrive over a
// valid/ready handshake, wait in a circular buffer, and are serialised as
// start bit, DW data bits LSB first, optional parity bit and STOP_BITS stop
// bits, each bit lasting BAUD_COUNTER clocks. Queued words leave back-to-back
// with no idle time between frames.
//
// Ports:
//   clk_i        : clock, everything on the rising edge
//   rst_i        : synchronous active-high reset; aborts any frame, flushes the FIFO
//   s_if         : slave side of the data/valid/ready handshake
//   Tx           : serial line, idle high, driven from a flop
//   busy_o       : high from the first start-bit clock to the last stop-bit clock
//   fifo_count_o : words waiting in the FIFO (the word on the line is not counted)
module uart_tx_fifo #(
  parameter int  DW           = 8,
  parameter real CLOCK        = 100e6,
  parameter int  BAUD_RATE    = 20000000,
  parameter int  BAUD_COUNTER = int'(CLOCK / BAUD_RATE),
  parameter int  BRW          = $clog2(BAUD_COUNTER + 1),
  parameter int  FIFO_DEPTH   = 4,
  parameter int  PARITY       = 0,
  parameter int  STOP_BITS    = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  uart_tx_fifo_if.slave                    s_if,
  output logic                             Tx,
  output logic                             busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [BRW-1:0]  BAUD_LAST = BRW'(BAUD_COUNTER - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DW - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Odd parity makes the total count of ones odd, even parity makes it even.
  function automatic logic parity_bit(input logic [DW-1:0] word);
    return (PARITY == 1) ? ~^word : ^word;
  endfunction

  logic [DW-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [BRW-1:0] r_baud;
  logic [3:0]     r_bit;
  logic [3:0]     w_bit_nxt;
  logic [DW-1:0]  r_shift;
  logic           r_par;
  logic           r_tx;
  logic           w_tx_nxt;

  logic           w_full;
  logic           w_ready;
  logic           w_push;
  logic           w_pop;
  logic           w_shift;
  logic           w_tick;

  // Ready depends only on the stored count (and reset), never on valid, so
  // a producer may wait for ready before raising valid without deadlock.
  assign w_full       = (r_count == FULL_CNT);
  assign w_ready      = !w_full && !rst_i;
  assign w_push       = s_if.valid && w_ready;
  assign w_tick       = (r_baud == BAUD_LAST);

  assign s_if.ready   = w_ready;
  assign Tx           = r_tx;
  assign busy_o       = (r_state != S_IDLE);
  assign fifo_count_o = r_count;

  // Next-state logic. Tx is registered, so each transition also selects the
  // line level for the bit being entered. r_bit counts data bits in DATA and
  // stop bits in STOP.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (r_count != '0) begin
          w_state_nxt = S_START;
          w_pop       = 1'b1;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit == DATA_LAST) begin
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            w_bit_nxt   = '0;
            w_tx_nxt    = (PARITY != 0) ? r_par : 1'b1;
          end else begin
            // r_shift[1] becomes the new LSB at this same edge.
            w_bit_nxt = r_bit + 4'd1;
            w_shift   = 1'b1;
            w_tx_nxt  = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bit == STOP_LAST) begin
            // Chain straight into the next frame when a word is waiting.
            if (r_count != '0) begin
              w_state_nxt = S_START;
              w_pop       = 1'b1;
              w_tx_nxt    = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // Control state: FSM, baud timer, FIFO pointers and count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b1;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      if (r_state == S_IDLE || w_tick) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
      // Power-of-two depth: pointers wrap by natural overflow.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Datapath storage: FIFO memory, shift register and latched parity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_if.data;
    end
    if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
      r_par   <= parity_bit(r_mem[r_rd_ptr]);
    end else if (w_shift) begin
      r_shift <= r_shift >> 1;
    end
  end

endmodule
